// File: rtl/mem1_stage_nlane_pkg.sv
// Shared types and field widths for the N-lane MEM1 stage and its request arbiter.
package mem1_stage_nlane_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDrain = 2'd2
    } m1_state_e;

    localparam int unsigned MaxLanes = 4;
    localparam int unsigned DefBusW  = 160;
    localparam int unsigned DefFwdW  = 38;

    // Per-lane request field widths; lane i of a packed field vector sits at [i*W +: W].
    localparam int unsigned SizeW = 2;
    localparam int unsigned StrbW = 4;
    localparam int unsigned AddrW = 32;
    localparam int unsigned DataW = 32;

endpackage

// File: rtl/mem1_stage_nlane_if.sv
// SRAM-like data request channel between MEM1 (master) and the data memory (slave).
interface mem1_stage_nlane_if;
    import mem1_stage_nlane_pkg::*;

    logic             data_sram_req;
    logic             data_sram_wr;
    logic [SizeW-1:0] data_sram_size;
    logic [StrbW-1:0] data_sram_wstrb;
    logic [AddrW-1:0] data_sram_addr;
    logic [DataW-1:0] data_sram_wdata;
    logic             data_uncache;
    logic             data_sram_addr_ok;

    modport master (
        output data_sram_req,
        output data_sram_wr,
        output data_sram_size,
        output data_sram_wstrb,
        output data_sram_addr,
        output data_sram_wdata,
        output data_uncache,
        input  data_sram_addr_ok
    );

    modport slave (
        input  data_sram_req,
        input  data_sram_wr,
        input  data_sram_size,
        input  data_sram_wstrb,
        input  data_sram_addr,
        input  data_sram_wdata,
        input  data_uncache,
        output data_sram_addr_ok
    );

endinterface

// File: rtl/mem1_req_arbiter.sv
// Picks the lowest-index pending lane and muxes its request fields onto the shared channel.
module mem1_req_arbiter
    import mem1_stage_nlane_pkg::*;
#(
    parameter int unsigned LANES = 2
) (
    input  logic [LANES-1:0]       pend_i,
    input  logic [LANES-1:0]       wr_i,
    input  logic [LANES*SizeW-1:0] size_i,
    input  logic [LANES*StrbW-1:0] wstrb_i,
    input  logic [LANES*AddrW-1:0] addr_i,
    input  logic [LANES*DataW-1:0] wdata_i,
    input  logic [LANES-1:0]       uncache_i,
    output logic                   any_o,
    output logic [LANES-1:0]       pick_oh_o,
    output logic                   wr_o,
    output logic [SizeW-1:0]       size_o,
    output logic [StrbW-1:0]       wstrb_o,
    output logic [AddrW-1:0]       addr_o,
    output logic [DataW-1:0]       wdata_o,
    output logic                   uncache_o
);

    logic found;

    always_comb begin
        found     = 1'b0;
        pick_oh_o = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (pend_i[i] && !found) begin
                pick_oh_o[i] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    assign any_o = |pend_i;

    // One-hot AND-OR mux; all fields read zero when nothing is pending.
    always_comb begin
        wr_o      = 1'b0;
        size_o    = '0;
        wstrb_o   = '0;
        addr_o    = '0;
        wdata_o   = '0;
        uncache_o = 1'b0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (pick_oh_o[i]) begin
                wr_o      = wr_i[i];
                size_o    = size_i[i*SizeW +: SizeW];
                wstrb_o   = wstrb_i[i*StrbW +: StrbW];
                addr_o    = addr_i[i*AddrW +: AddrW];
                wdata_o   = wdata_i[i*DataW +: DataW];
                uncache_o = uncache_i[i];
            end
        end
    end

endmodule

// File: rtl/mem1_stage_nlane.sv
// N-lane EX->MEM2 pipeline register that serialises per-lane data requests over one channel,
// suppressing requests at and after an excepting lane and draining a presented request on flush.
module mem1_stage_nlane
    import mem1_stage_nlane_pkg::*;
#(
    parameter int unsigned LANES = 2,
    parameter int unsigned BUS_W = DefBusW,
    parameter int unsigned FWD_W = DefFwdW
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [LANES-1:0]           es_to_m1s_valid_i,
    input  logic [LANES*BUS_W-1:0]     es_to_m1s_bus_i,
    input  logic [LANES*FWD_W-1:0]     es_fwd_i,
    input  logic [LANES-1:0]           es_ex_i,
    input  logic [LANES-1:0]           es_mem_req_i,
    input  logic [LANES-1:0]           es_mem_wr_i,
    input  logic [LANES*SizeW-1:0]     es_mem_size_i,
    input  logic [LANES*StrbW-1:0]     es_mem_wstrb_i,
    input  logic [LANES*AddrW-1:0]     es_mem_addr_i,
    input  logic [LANES*DataW-1:0]     es_mem_wdata_i,
    input  logic [LANES-1:0]           es_mem_uncache_i,
    output logic                       m1s_allowin_o,
    output logic                       m1s_ex_o,
    input  logic                       m2s_allowin_i,
    input  logic                       m1s_flush_i,
    input  logic                       m1s_stall_i,
    output logic [LANES-1:0]           m1s_valid_o,
    output logic                       m1s_ready_go_o,
    output logic [LANES-1:0]           m1s_to_m2s_valid_o,
    output logic [LANES*BUS_W-1:0]     m1s_to_m2s_bus_o,
    output logic [LANES-1:0]           m1s_issued_o,
    output logic [LANES*(FWD_W+1)-1:0] m1s_fwd_bus_o,
    output logic                       m1s_cancel_o,
    mem1_stage_nlane_if.master         dsram_io
);

    localparam int unsigned FwdLaneW = FWD_W + 1;

    m1_state_e                  state_q, state_d;
    logic [LANES-1:0]           valid_q, valid_d;
    logic [LANES*BUS_W-1:0]     bus_q, bus_d;
    logic [LANES*FwdLaneW-1:0]  fwd_q, fwd_d;
    logic [LANES-1:0]           ex_q, ex_d;
    logic [LANES-1:0]           wr_q, wr_d;
    logic [LANES*SizeW-1:0]     size_q, size_d;
    logic [LANES*StrbW-1:0]     wstrb_q, wstrb_d;
    logic [LANES*AddrW-1:0]     addr_q, addr_d;
    logic [LANES*DataW-1:0]     wdata_q, wdata_d;
    logic [LANES-1:0]           unc_q, unc_d;
    logic [LANES-1:0]           pend_q, pend_d;
    logic [LANES-1:0]           issued_q, issued_d;
    logic                       cancel_q, cancel_d;

    logic                       pend_any;
    logic [LANES-1:0]           pick_oh;
    logic                       arb_wr, arb_unc;
    logic [SizeW-1:0]           arb_size;
    logic [StrbW-1:0]           arb_wstrb;
    logic [AddrW-1:0]           arb_addr;
    logic [DataW-1:0]           arb_wdata;

    logic                       req, hs, addr_ok, no_valid, ready_go, allowin, kill, ex_acc;
    logic [LANES-1:0]           ex_mask;

    mem1_req_arbiter #(
        .LANES (LANES)
    ) u_arb (
        .pend_i    (pend_q),
        .wr_i      (wr_q),
        .size_i    (size_q),
        .wstrb_i   (wstrb_q),
        .addr_i    (addr_q),
        .wdata_i   (wdata_q),
        .uncache_i (unc_q),
        .any_o     (pend_any),
        .pick_oh_o (pick_oh),
        .wr_o      (arb_wr),
        .size_o    (arb_size),
        .wstrb_o   (arb_wstrb),
        .addr_o    (arb_addr),
        .wdata_o   (arb_wdata),
        .uncache_o (arb_unc)
    );

    // pend only changes on a handshake, so the picked lane is stable while ISSUE/DRAIN waits.
    assign addr_ok  = dsram_io.data_sram_addr_ok;
    assign req      = (state_q == StIdle) ? (pend_any && !m1s_stall_i) : 1'b1;
    assign hs       = req && addr_ok;
    assign no_valid = ~|valid_q;
    assign ready_go = no_valid || (!m1s_stall_i && !pend_any && (state_q != StDrain));
    assign allowin  = no_valid || (ready_go && m2s_allowin_i);

    always_comb begin
        ex_acc  = 1'b0;
        ex_mask = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            ex_acc     = ex_acc | es_ex_i[i];
            ex_mask[i] = ex_acc;
        end
    end

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        bus_d    = bus_q;
        fwd_d    = fwd_q;
        ex_d     = ex_q;
        wr_d     = wr_q;
        size_d   = size_q;
        wstrb_d  = wstrb_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        unc_d    = unc_q;
        pend_d   = pend_q;
        issued_d = issued_q;
        cancel_d = 1'b0;
        kill     = 1'b0;

        case (state_q)
            StDrain: begin
                if (addr_ok) begin
                    kill     = 1'b1;
                    cancel_d = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: begin
                if (m1s_flush_i) begin
                    // A presented request may not be withdrawn, so wait it out in DRAIN.
                    if (req && !addr_ok) begin
                        state_d = StDrain;
                    end else begin
                        kill    = 1'b1;
                        state_d = StIdle;
                    end
                end else if (hs) begin
                    pend_d   = pend_q & ~pick_oh;
                    issued_d = issued_q | pick_oh;
                    state_d  = StIdle;
                end else if (req) begin
                    state_d = StIssue;
                end

                if (!m1s_flush_i && allowin) begin
                    valid_d  = es_to_m1s_valid_i;
                    issued_d = '0;
                    for (int i = 0; i < int'(LANES); i++) begin
                        if (es_to_m1s_valid_i[i]) begin
                            bus_d[i*BUS_W +: BUS_W]       = es_to_m1s_bus_i[i*BUS_W +: BUS_W];
                            fwd_d[i*FwdLaneW +: FwdLaneW] = {1'b1, es_fwd_i[i*FWD_W +: FWD_W]};
                            ex_d[i]                       = es_ex_i[i];
                            wr_d[i]                       = es_mem_wr_i[i];
                            size_d[i*SizeW +: SizeW]      = es_mem_size_i[i*SizeW +: SizeW];
                            wstrb_d[i*StrbW +: StrbW]     = es_mem_wstrb_i[i*StrbW +: StrbW];
                            addr_d[i*AddrW +: AddrW]      = es_mem_addr_i[i*AddrW +: AddrW];
                            wdata_d[i*DataW +: DataW]     = es_mem_wdata_i[i*DataW +: DataW];
                            unc_d[i]                      = es_mem_uncache_i[i];
                            pend_d[i]                     = es_mem_req_i[i] & ~ex_mask[i];
                        end else begin
                            bus_d[i*BUS_W +: BUS_W]       = '0;
                            fwd_d[i*FwdLaneW +: FwdLaneW] = '0;
                            ex_d[i]                       = 1'b0;
                            wr_d[i]                       = 1'b0;
                            size_d[i*SizeW +: SizeW]      = '0;
                            wstrb_d[i*StrbW +: StrbW]     = '0;
                            addr_d[i*AddrW +: AddrW]      = '0;
                            wdata_d[i*DataW +: DataW]     = '0;
                            unc_d[i]                      = 1'b0;
                            pend_d[i]                     = 1'b0;
                        end
                    end
                end
            end
        endcase

        if (kill) begin
            valid_d  = '0;
            pend_d   = '0;
            issued_d = '0;
            for (int i = 0; i < int'(LANES); i++) begin
                fwd_d[i*FwdLaneW + FWD_W] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            valid_q  <= '0;
            bus_q    <= '0;
            fwd_q    <= '0;
            ex_q     <= '0;
            wr_q     <= '0;
            size_q   <= '0;
            wstrb_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            unc_q    <= '0;
            pend_q   <= '0;
            issued_q <= '0;
            cancel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            bus_q    <= bus_d;
            fwd_q    <= fwd_d;
            ex_q     <= ex_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            wstrb_q  <= wstrb_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            unc_q    <= unc_d;
            pend_q   <= pend_d;
            issued_q <= issued_d;
            cancel_q <= cancel_d;
        end
    end

    assign m1s_allowin_o      = allowin;
    assign m1s_ready_go_o     = ready_go;
    assign m1s_ex_o           = |(ex_q & valid_q);
    assign m1s_valid_o        = valid_q;
    assign m1s_to_m2s_valid_o = valid_q & {LANES{ready_go && !m1s_flush_i}};
    assign m1s_to_m2s_bus_o   = bus_q;
    assign m1s_issued_o       = issued_q;
    assign m1s_fwd_bus_o      = fwd_q;
    assign m1s_cancel_o       = cancel_q;

    assign dsram_io.data_sram_req   = req;
    assign dsram_io.data_sram_wr    = arb_wr;
    assign dsram_io.data_sram_size  = arb_size;
    assign dsram_io.data_sram_wstrb = arb_wstrb;
    assign dsram_io.data_sram_addr  = arb_addr;
    assign dsram_io.data_sram_wdata = arb_wdata;
    assign dsram_io.data_uncache    = arb_unc;

endmodule

// File: tb/tb_mem1_stage_nlane.sv
// Directed bench for mem1_stage_nlane (LANES=2): scoreboarded request order plus handshake checks.
module tb_mem1_stage_nlane;

    localparam int unsigned LANES = 2;
    localparam int unsigned BUS_W = 160;
    localparam int unsigned FWD_W = 38;
    localparam int unsigned FL    = FWD_W + 1;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [LANES-1:0]         es_valid, es_ex, es_mem_req, es_mem_wr, es_mem_unc;
    logic [LANES*BUS_W-1:0]   es_bus;
    logic [LANES*FWD_W-1:0]   es_fwd;
    logic [LANES*2-1:0]       es_mem_size;
    logic [LANES*4-1:0]       es_mem_wstrb;
    logic [LANES*32-1:0]      es_mem_addr, es_mem_wdata;
    logic                     allowin, m1s_ex, m2s_allowin, flush, stall, ready_go, cancel;
    logic [LANES-1:0]         m1s_valid, to_m2s_valid, issued;
    logic [LANES*BUS_W-1:0]   to_m2s_bus;
    logic [LANES*FL-1:0]      fwd_bus;

    logic [LANES*BUS_W-1:0]   exp_bus;
    logic [LANES*FL-1:0]      exp_fwd;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
    } req_t;

    req_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    mem1_stage_nlane_if dsram ();

    mem1_stage_nlane #(
        .LANES (LANES),
        .BUS_W (BUS_W),
        .FWD_W (FWD_W)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .es_to_m1s_valid_i  (es_valid),
        .es_to_m1s_bus_i    (es_bus),
        .es_fwd_i           (es_fwd),
        .es_ex_i            (es_ex),
        .es_mem_req_i       (es_mem_req),
        .es_mem_wr_i        (es_mem_wr),
        .es_mem_size_i      (es_mem_size),
        .es_mem_wstrb_i     (es_mem_wstrb),
        .es_mem_addr_i      (es_mem_addr),
        .es_mem_wdata_i     (es_mem_wdata),
        .es_mem_uncache_i   (es_mem_unc),
        .m1s_allowin_o      (allowin),
        .m1s_ex_o           (m1s_ex),
        .m2s_allowin_i      (m2s_allowin),
        .m1s_flush_i        (flush),
        .m1s_stall_i        (stall),
        .m1s_valid_o        (m1s_valid),
        .m1s_ready_go_o     (ready_go),
        .m1s_to_m2s_valid_o (to_m2s_valid),
        .m1s_to_m2s_bus_o   (to_m2s_bus),
        .m1s_issued_o       (issued),
        .m1s_fwd_bus_o      (fwd_bus),
        .m1s_cancel_o       (cancel),
        .dsram_io           (dsram)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [LANES*BUS_W-1:0] got,
                       input logic [LANES*BUS_W-1:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one bundle, check it is accepted, and record expected held payloads.
    task automatic load(input logic [1:0] v, input logic [1:0] ex, input logic [1:0] mreq,
                        input logic [1:0] mwr, input logic [31:0] a0, input logic [31:0] a1);
        logic [95:0] t;
        for (int k = 0; k < 10; k++) es_bus[k*32 +: 32] = $urandom;
        for (int k = 0; k < 3; k++) t[k*32 +: 32] = $urandom;
        es_fwd       = t[LANES*FWD_W-1:0];
        es_valid     = v;
        es_ex        = ex;
        es_mem_req   = mreq;
        es_mem_wr    = mwr;
        es_mem_addr  = {a1, a0};
        es_mem_wdata = {a1 ^ 32'hcafe_0000, a0 ^ 32'hbeef_0000};
        es_mem_size  = 4'b1010;
        es_mem_wstrb = 8'hff;
        es_mem_unc   = 2'b00;
        for (int i = 0; i < int'(LANES); i++) begin
            exp_bus[i*BUS_W +: BUS_W] = v[i] ? es_bus[i*BUS_W +: BUS_W] : '0;
            exp_fwd[i*FL +: FL]       = v[i] ? {1'b1, es_fwd[i*FWD_W +: FWD_W]} : '0;
        end
        #1;
        chk("allowin_at_load", allowin, 1);
        cyc();
        es_valid   = '0;
        es_ex      = '0;
        es_mem_req = '0;
    endtask

    // Wait for a request, hold addr_ok low for 'delay' cycles, then accept it.
    task automatic serve(input int delay);
        int   w;
        req_t e;
        w = 0;
        #1;
        while (!dsram.data_sram_req && w < 20) begin
            cyc();
            #1;
            w++;
        end
        chk("req_seen", dsram.data_sram_req, 1);
        chk("sb_has_entry", sb.size() > 0, 1);
        if (sb.size() == 0) return;
        e = sb[0];
        for (int d = 0; d < delay; d++) begin
            chk("addr_stable", dsram.data_sram_addr, e.addr);
            chk("req_held", dsram.data_sram_req, 1);
            chk("allowin_wait", allowin, 0);
            cyc();
            #1;
        end
        dsram.data_sram_addr_ok = 1'b1;
        #1;
        e = sb.pop_front();
        chk("hs_addr", dsram.data_sram_addr, e.addr);
        chk("hs_wr", dsram.data_sram_wr, e.wr);
        cyc();
        dsram.data_sram_addr_ok = 1'b0;
    endtask

    initial begin
        es_valid = '0; es_ex = '0; es_mem_req = '0; es_mem_wr = '0; es_mem_unc = '0;
        es_bus = '0; es_fwd = '0; es_mem_size = '0; es_mem_wstrb = '0;
        es_mem_addr = '0; es_mem_wdata = '0;
        m2s_allowin = 1'b1; flush = 1'b0; stall = 1'b0;
        dsram.data_sram_addr_ok = 1'b0;
        exp_bus = '0; exp_fwd = '0;

        // Reset state
        repeat (2) cyc();
        chk("rst_valid", m1s_valid, 0);
        chk("rst_issued", issued, 0);
        chk("rst_fwd", fwd_bus, 0);
        chk("rst_cancel", cancel, 0);
        chk("rst_req", dsram.data_sram_req, 0);
        chk("rst_allowin", allowin, 1);
        rst = 1'b0;
        cyc();

        // Lane 1 store to 0x1000, accepted on first cycle
        load(2'b11, 2'b00, 2'b10, 2'b10, 32'h0, 32'h1000);
        sb.push_back('{addr: 32'h1000, wr: 1'b1});
        #1;
        chk("t1_ready_go_before", ready_go, 0);
        serve(0);
        #1;
        chk("t1_issued", issued, 2'b10);
        chk("t1_ready_go_after", ready_go, 1);
        chk("t1_req_done", dsram.data_sram_req, 0);
        chk("t1_to_m2s_valid", to_m2s_valid, 2'b11);
        chk("t1_bus", to_m2s_bus, exp_bus);
        chk("t1_fwd", fwd_bus, exp_fwd);
        cyc();

        // Two loads, addr_ok delayed 3 cycles each, lane order
        load(2'b11, 2'b00, 2'b11, 2'b00, 32'h20, 32'h24);
        sb.push_back('{addr: 32'h20, wr: 1'b0});
        sb.push_back('{addr: 32'h24, wr: 1'b0});
        serve(3);
        #1;
        chk("t2_issued_mid", issued, 2'b01);
        chk("t2_allowin_mid", allowin, 0);
        serve(3);
        #1;
        chk("t2_issued", issued, 2'b11);
        chk("t2_allowin_done", allowin, 1);
        cyc();

        // Exception on lane 0 suppresses both lanes
        load(2'b11, 2'b01, 2'b11, 2'b00, 32'h200, 32'h204);
        #1;
        chk("t3_req", dsram.data_sram_req, 0);
        chk("t3_ex", m1s_ex, 1);
        chk("t3_ready_go", ready_go, 1);
        cyc();
        #1;
        chk("t3_ex_gone", m1s_ex, 0);

        // Exception on lane 1 suppresses only lane 1
        load(2'b11, 2'b10, 2'b11, 2'b00, 32'h300, 32'h304);
        sb.push_back('{addr: 32'h300, wr: 1'b0});
        serve(1);
        #1;
        chk("t3b_issued", issued, 2'b01);
        chk("t3b_req_off", dsram.data_sram_req, 0);
        chk("t3b_ex", m1s_ex, 1);
        cyc();

        // Flush during ISSUE, drained request completes 2 cycles later
        load(2'b01, 2'b00, 2'b01, 2'b00, 32'h40, 32'h44);
        sb.push_back('{addr: 32'h40, wr: 1'b0});
        #1;
        chk("t4_bus_invalid_zero", to_m2s_bus, exp_bus);
        chk("t4_req", dsram.data_sram_req, 1);
        cyc();
        flush = 1'b1;
        #1;
        chk("t4_flush_req", dsram.data_sram_req, 1);
        chk("t4_flush_handoff", to_m2s_valid, 0);
        cyc();
        flush = 1'b0;
        #1;
        chk("t4_drain1_req", dsram.data_sram_req, 1);
        chk("t4_drain1_allowin", allowin, 0);
        chk("t4_drain1_cancel", cancel, 0);
        cyc();
        #1;
        chk("t4_drain2_req", dsram.data_sram_req, 1);
        chk("t4_drain2_allowin", allowin, 0);
        dsram.data_sram_addr_ok = 1'b1;
        #1;
        chk("t4_drain_addr", dsram.data_sram_addr, sb.pop_front().addr);
        cyc();
        dsram.data_sram_addr_ok = 1'b0;
        #1;
        chk("t4_cancel", cancel, 1);
        chk("t4_valid", m1s_valid, 0);
        chk("t4_req_off", dsram.data_sram_req, 0);
        chk("t4_fwd_valid", {fwd_bus[2*FL-1], fwd_bus[FL-1]}, 2'b00);
        cyc();
        #1;
        chk("t4_cancel_pulse", cancel, 0);
        chk("t4_allowin", allowin, 1);

        // Stall before issue, then stall raised while req is up
        stall = 1'b1;
        load(2'b01, 2'b00, 2'b01, 2'b00, 32'h80, 32'h0);
        sb.push_back('{addr: 32'h80, wr: 1'b0});
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t5_stalled_req", dsram.data_sram_req, 0);
            chk("t5_stalled_rg", ready_go, 0);
            cyc();
        end
        stall = 1'b0;
        #1;
        chk("t5_req_up", dsram.data_sram_req, 1);
        cyc();
        stall = 1'b1;
        #1;
        chk("t5_req_persist", dsram.data_sram_req, 1);
        cyc();
        #1;
        chk("t5_req_persist2", dsram.data_sram_req, 1);
        dsram.data_sram_addr_ok = 1'b1;
        #1;
        chk("t5_addr", dsram.data_sram_addr, sb.pop_front().addr);
        cyc();
        dsram.data_sram_addr_ok = 1'b0;
        #1;
        chk("t5_issued", issued, 2'b01);
        chk("t5_rg_stalled", ready_go, 0);
        stall = 1'b0;
        #1;
        chk("t5_rg", ready_go, 1);
        cyc();

        // Async reset mid-ISSUE
        load(2'b10, 2'b00, 2'b10, 2'b01, 32'h0, 32'h100);
        cyc();
        #1;
        chk("t6_req_before", dsram.data_sram_req, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_req_reset", dsram.data_sram_req, 0);
        chk("t6_valid_reset", m1s_valid, 0);
        cyc();
        rst = 1'b0;
        cyc();
        #1;
        chk("t6_allowin", allowin, 1);

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem1_stage_nlane.md
Name: mem1_stage_nlane

Overview:
- Parametrised successor to the dual-issue MEM1 stage: an N-lane pipeline register between EX and MEM2.
- Any lane, not just lane 0, may carry a data-memory request. Requests in one bundle are issued serially, in lane order, over the single data SRAM-like request channel.
- Adds an exception-suppression rule and a flush-safe drain state, so a request already presented is never withdrawn before addr_ok.

Parameters:
- LANES, 2, issue width (1..4).
- BUS_W, 160, per-lane EX-to-MEM1 payload width, passed through unchanged.
- FWD_W, 38, per-lane forwarding payload width; an added valid bit is prepended.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- es_to_m1s_valid  in  LANES  per-lane valid from EX
- es_to_m1s_bus  in  LANES*BUS_W  per-lane payload; lane i at [i*BUS_W +: BUS_W]
- es_fwd  in  LANES*FWD_W  per-lane forwarding payload
- es_ex  in  LANES  per-lane exception flag
- es_mem_req  in  LANES  lane carries a memory access
- es_mem_wr  in  LANES  1 = store
- es_mem_size  in  2*LANES  access size
- es_mem_wstrb  in  4*LANES  byte strobes
- es_mem_addr  in  32*LANES  address
- es_mem_wdata  in  32*LANES  store data
- es_mem_uncache  in  LANES  uncached attribute
- m1s_allowin  out  1  stage accepts a bundle this cycle
- m1s_ex  out  1  any valid held lane has es_ex set
- m2s_allowin  in  1  MEM2 accepts
- m1s_flush  in  1  kill held bundle (exception or eret taken downstream)
- m1s_stall  in  1  hazard stall
- m1s_valid  out  LANES  held-lane valid
- m1s_ready_go  out  1  bundle may leave
- m1s_to_m2s_valid  out  LANES  handoff valid
- m1s_to_m2s_bus  out  LANES*BUS_W  held payloads
- m1s_issued  out  LANES  lanes whose request received addr_ok; MEM2 expects data_ok for these
- m1s_fwd_bus  out  LANES*(FWD_W+1)  {valid, payload} per lane
- m1s_cancel  out  1  one-cycle pulse: a drained request completed after flush; MEM2 must discard its data_ok
- data_sram_req, data_sram_wr, data_sram_size[2], data_sram_wstrb[4], data_sram_addr[32], data_sram_wdata[32], data_uncache  out  request channel
- data_sram_addr_ok  in  1  request accepted

Behaviour:
- Reset: m1s_valid, m1s_issued, m1s_fwd_bus, m1s_cancel, data_sram_req all 0. State IDLE. Stored payloads 0. Reset mid-drain abandons the request.
- Load, when m1s_allowin is high:
  - m1s_valid <= es_to_m1s_valid.
  - Per lane: payload, fwd = {1, es_fwd}, and request fields are captured if that lane is valid, else zeroed.
  - pend[i] <= es_mem_req[i] & valid[i] & ~ex_mask[i], where ex_mask[i] = OR of es_ex[0..i]. The excepting lane and all younger lanes are suppressed.
  - m1s_issued <= 0.
- State IDLE:
  - If pend is non-zero and m1s_stall is low, present the lowest-index pending lane on data_sram_* with req = 1 and enter ISSUE.
  - data_sram_req is combinational from state and lane, so the request appears in the same cycle as IDLE exit.
- State ISSUE:
  - Hold all request fields stable until addr_ok.
  - On addr_ok: clear pend[k], set m1s_issued[k]. Next pending lane follows in the next cycle; with none left, go to IDLE.
  - Stall raised while req is high does not drop req.
- m1s_ready_go = (no valid lanes) | (!m1s_stall & pend == 0 & state != DRAIN).
- m1s_allowin = (no valid lanes) | (m1s_ready_go & m2s_allowin).
- m1s_to_m2s_valid[i] = m1s_valid[i] & m1s_ready_go & !m1s_flush.
- m1s_flush:
  - In IDLE, or in ISSUE with addr_ok in the same cycle: clear m1s_valid, pend, m1s_issued and fwd valid next cycle; go to IDLE.
  - In ISSUE with addr_ok low: enter DRAIN and keep the same request asserted. On addr_ok, pulse m1s_cancel, clear everything and go to IDLE.
  - m1s_allowin is 0 throughout DRAIN.
- Back-to-back bundles: a new bundle loads the same cycle the old one leaves. Its first request appears the following cycle at the earliest.
- m1s_ex is combinational from held es_ex & m1s_valid.

Decomposition:
- Shared header: lane-field offsets, FWD_W, state encodings (IDLE = 0, ISSUE = 1, DRAIN = 2).
- One sub-module, mem1_req_arbiter: lowest-set-bit picker over pend, plus the request field mux.

Test Plan:
- LANES = 2, lane 1 only is a store to 0x1000, addr_ok on the first cycle → one req with addr 0x1000 and wr = 1; m1s_issued = 2'b10; ready_go rises the cycle after the handshake.
- Both lanes load 0x20 and 0x24, addr_ok delayed 3 cycles each → requests issued lane 0 then lane 1, fields stable while waiting; m1s_allowin = 0 until both are accepted.
- es_ex = 2'b01 with both lanes requesting → no data_sram_req; m1s_ex = 1; ready_go = 1 when not stalled.
- Flush asserted during ISSUE with addr_ok low, addr_ok 2 cycles later → req held 2 cycles, m1s_cancel pulses once, m1s_valid = 0, allowin stays 0 during drain.
- m1s_stall high before issue → no req while stalled; stall raised after req is already high → req persists to addr_ok.
- Async reset asserted mid-ISSUE between clock edges → data_sram_req and m1s_valid drop to 0 immediately.
